// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end: word width, reset PC,
// next-PC selector encodings and the fetch FSM state type.
package riscv_pkg;

    localparam int          RV_XLEN     = 32;
    localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

    // Encoding of the control decoder's next_pc_selector field
    localparam logic [1:0] NEXT_PC_SEQ      = 2'b00;
    localparam logic [1:0] NEXT_PC_BRANCH   = 2'b01;
    localparam logic [1:0] NEXT_PC_JUMP     = 2'b10;
    localparam logic [1:0] NEXT_PC_RESERVED = 2'b11;

    // Single-outstanding fetch sequence; FAULT is terminal until reset
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_next_pc.sv
// next_pc_logic: combinational next-PC selection for the fetch stage.
// Sequential and reserved selectors advance by one word (modulo 2^XLEN),
// a branch redirects only when taken, a jump clears target bit 0.
// Any result that is not word aligned is flagged as misaligned.
module next_pc_logic
    import riscv_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      next_pc_selector,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] target_address,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic [XLEN-1:0] seq_pc;

    assign seq_pc = pc + XLEN'(4);

    // Choose the successor address from the selector encoding
    always_comb begin
        next_pc = seq_pc;
        case (next_pc_selector)
            NEXT_PC_BRANCH: next_pc = branch_taken ? target_address : seq_pc;
            NEXT_PC_JUMP:   next_pc = {target_address[XLEN-1:1], 1'b0};
            default:        next_pc = seq_pc;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register plus a single-outstanding instruction
// memory request sequencer. The fetched word is buffered and offered to
// decode; when it retires, the next PC is computed by next_pc_logic.
// A misaligned next PC parks the stage in a sticky FAULT state.
// Optional macro FETCH_PERF_COUNTER_EN adds a 64-bit retired-instruction
// counter output (instret_count).
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN     = RV_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = RV_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    input  logic [1:0]      next_pc_selector,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] target_address,
    output logic            fetch_fault
`ifdef FETCH_PERF_COUNTER_EN
    ,
    output logic [63:0]     instret_count
`endif
);

    fetch_state_t    state_reg;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] inst_reg;
    logic            fault_reg;
    logic [XLEN-1:0] next_pc;
    logic            next_pc_misaligned;
    logic            retire;

    next_pc_logic #(
        .XLEN(XLEN)
    ) u_next_pc_logic (
        .pc               (pc_reg),
        .next_pc_selector (next_pc_selector),
        .branch_taken     (branch_taken),
        .target_address   (target_address),
        .next_pc          (next_pc),
        .misaligned       (next_pc_misaligned)
    );

    // The buffered instruction retires on the decode handshake
    assign retire = (state_reg == HOLD) && inst_ready;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic; responses outside WAIT are ignored
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = REQ;
            REQ:     if (imem_req_ready)  state_next = WAIT;
            WAIT:    if (imem_resp_valid) state_next = HOLD;
            HOLD:    if (inst_ready)      state_next = next_pc_misaligned ? FAULT : REQ;
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: request in REQ, instruction offered in HOLD
    always_comb begin
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        case (state_reg)
            REQ:     imem_req_valid = 1'b1;
            HOLD:    inst_valid     = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture the response, advance or freeze the PC, latch faults
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg    <= RESET_PC;
            inst_reg  <= '0;
            fault_reg <= 1'b0;
        end else begin
            if ((state_reg == WAIT) && imem_resp_valid) begin
                inst_reg <= imem_resp_data;
            end
            if (retire) begin
                if (next_pc_misaligned) begin
                    fault_reg <= 1'b1;
                end else begin
                    pc_reg <= next_pc;
                end
            end
        end
    end

    assign imem_req_addr = pc_reg;
    assign pc            = pc_reg;
    assign inst          = inst_reg;
    assign fetch_fault   = fault_reg;

`ifdef FETCH_PERF_COUNTER_EN
    logic [63:0] instret_reg;

    // Count non-faulting retirements; wraps naturally at 2^64
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_reg <= '0;
        end else if (retire && !next_pc_misaligned) begin
            instret_reg <= instret_reg + 64'd1;
        end
    end

    assign instret_count = instret_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized redirects, stalls and memory latencies, checked against a
// behavioural next-PC/fault model. FETCH_PERF_COUNTER_EN also checks the
// retired-instruction counter.
module tb_instruction_fetch;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_RSVD   = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  next_pc_selector;
    logic        branch_taken;
    logic [31:0] target_address;
    logic        fetch_fault;
`ifdef FETCH_PERF_COUNTER_EN
    logic [63:0] instret_count;
`endif

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_pc;
    logic        exp_fault;
    logic [63:0] exp_instret;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst             (inst),
        .pc               (pc),
        .next_pc_selector (next_pc_selector),
        .branch_taken     (branch_taken),
        .target_address   (target_address),
        .fetch_fault      (fetch_fault)
`ifdef FETCH_PERF_COUNTER_EN
        ,
        .instret_count    (instret_count)
`endif
    );

    // Memory contents: address 0 holds addi x0,x0,0 (0x13)
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, got);
        end
    endtask

    task automatic check_reset_values();
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_fault", fetch_fault, 1'b0);
`ifdef FETCH_PERF_COUNTER_EN
        check("rst_instret", instret_count, 64'd0);
`endif
    endtask

    // Pulse reset; optionally present a stale response right at release
    task automatic reset_pulse(input bit late_resp);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n       = 1'b1;
        exp_pc      = 32'h0;
        exp_fault   = 1'b0;
        exp_instret = 64'd0;
        if (late_resp) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hDEAD_BEEF;
        end
        #1;
        check("idle_no_req", imem_req_valid, 1'b0);
        @(negedge clk);
        imem_resp_valid = 1'b0;
        check("first_req_cycle2", imem_req_valid, 1'b1);
        check("first_req_addr", imem_req_addr, 32'h0);
        check("late_resp_dropped", inst, 32'h0);
        check("late_resp_no_valid", inst_valid, 1'b0);
    endtask

    // One fetch: optional request stall, then response after latency cycles
    task automatic fetch_one(input int stall, input int latency);
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", imem_req_valid, 1'b1);
        if (!imem_req_valid) return;
        check("req_addr", imem_req_addr, exp_pc);
        for (int i = 0; i < stall; i++) begin
            imem_req_ready  = 1'b0;
            imem_resp_valid = (i == 0);
            imem_resp_data  = 32'hBAD0_0000 | 32'(i);
            @(negedge clk);
            check("stall_valid", imem_req_valid, 1'b1);
            check("stall_addr", imem_req_addr, exp_pc);
        end
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("wait_no_req", imem_req_valid, 1'b0);
        for (int i = 1; i < latency; i++) @(negedge clk);
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(exp_pc);
        @(negedge clk);
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        check("inst_valid", inst_valid, 1'b1);
        check("inst", inst, mem_word(exp_pc));
        check("inst_pc", pc, exp_pc);
    endtask

    // Retire the held instruction after `hold` idle cycles; model next PC
    task automatic retire(input logic [1:0] sel, input logic taken,
                          input logic [31:0] target, input int hold);
        logic [31:0] nxt;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", inst_valid, 1'b1);
            check("hold_inst", inst, mem_word(exp_pc));
        end
        if (sel == SEL_BRANCH && taken) nxt = target;
        else if (sel == SEL_JUMP)       nxt = target - 32'(target % 2);
        else                            nxt = exp_pc + 32'd4;
        inst_ready       = 1'b1;
        next_pc_selector = sel;
        branch_taken     = taken;
        target_address   = target;
        @(negedge clk);
        inst_ready       = 1'b0;
        next_pc_selector = 2'($urandom);
        branch_taken     = 1'($urandom);
        target_address   = $urandom;
        if (nxt % 4 != 0) begin
            exp_fault = 1'b1;
        end else begin
            exp_pc      = nxt;
            exp_instret = exp_instret + 64'd1;
        end
        check("retire_fault", fetch_fault, exp_fault);
        check("retire_pc", pc, exp_pc);
        check("retire_drop_valid", inst_valid, 1'b0);
`ifdef FETCH_PERF_COUNTER_EN
        check("instret", instret_count, exp_instret);
`endif
    endtask

    initial begin
        rst_n            = 1'b0;
        imem_req_ready   = 1'b0;
        imem_resp_valid  = 1'b0;
        imem_resp_data   = '0;
        inst_ready       = 1'b0;
        next_pc_selector = '0;
        branch_taken     = 1'b0;
        target_address   = '0;
        exp_pc           = 32'h0;
        exp_fault        = 1'b0;
        exp_instret      = 64'd0;
        repeat (2) @(negedge clk);
        reset_pulse(1'b0);

        // Basic sequential fetch, then a stalled request with spurious response
        fetch_one(0, 1);
        retire(SEL_SEQ, 1'b0, 32'h0, 0);
        fetch_one(5, 2);
        retire(SEL_RSVD, 1'b1, 32'h0000_0040, 1);
        fetch_one(0, 1);

        // Branch taken / not taken from 0x100
        retire(SEL_JUMP, 1'b0, 32'h0000_0100, 0);
        fetch_one(0, 1);
        retire(SEL_BRANCH, 1'b1, 32'h0000_0080, 0);
        fetch_one(0, 1);
        retire(SEL_JUMP, 1'b0, 32'h0000_0100, 0);
        fetch_one(0, 1);
        retire(SEL_BRANCH, 1'b0, 32'h0000_0080, 0);
        fetch_one(0, 1);

        // PC wrap-around
        retire(SEL_JUMP, 1'b0, 32'hFFFF_FFFC, 0);
        fetch_one(0, 1);
        retire(SEL_SEQ, 1'b0, 32'h0, 0);
        fetch_one(1, 1);

        // Randomized aligned redirects, stalls and latencies
        for (int k = 0; k < 30; k++) begin
            logic [1:0]  sel;
            logic [31:0] tgt;
            sel = 2'($urandom_range(0, 3));
            tgt = $urandom & 32'hFFFF_FFFC;
            if (sel == SEL_JUMP) tgt = tgt | 32'($urandom_range(0, 1));
            retire(sel, 1'($urandom), tgt, $urandom_range(0, 2));
            fetch_one($urandom_range(0, 3), $urandom_range(1, 3));
        end

        // Jump bit0 clearing, then misaligned jump into FAULT
        retire(SEL_JUMP, 1'b0, 32'h0000_0200, 0);
        fetch_one(0, 1);
        retire(SEL_JUMP, 1'b0, 32'h0000_0301, 0);
        fetch_one(0, 1);
        retire(SEL_JUMP, 1'b0, 32'h0000_0200, 0);
        fetch_one(0, 1);
        retire(SEL_JUMP, 1'b0, 32'h0000_0302, 0);
        for (int i = 0; i < 5; i++) begin
            imem_resp_valid = (i == 1);
            imem_req_ready  = 1'b1;
            @(negedge clk);
            check("fault_sticky", fetch_fault, 1'b1);
            check("fault_pc", pc, 32'h0000_0200);
            check("fault_no_req", imem_req_valid, 1'b0);
            check("fault_no_inst", inst_valid, 1'b0);
        end
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b0;
        reset_pulse(1'b0);

        // Three retirements, then reset mid-WAIT with a late response
        for (int k = 0; k < 3; k++) begin
            fetch_one(0, 1);
            retire(SEL_SEQ, 1'b0, 32'h0, 0);
        end
        check("three_retired_pc", pc, 32'h0000_000C);
        while (!imem_req_valid) @(negedge clk);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("in_wait", imem_req_valid, 1'b0);
        reset_pulse(1'b1);
        fetch_one(0, 1);
        retire(SEL_SEQ, 1'b0, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute watchdog so the run always ends
    initial begin
        #200000;
        tests_failed++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
